// File: rtl/pipelined_rca.sv
// rtl/pipelined_rca.sv - segmented ripple-carry adder/subtractor pipeline, one SEG-bit slice per stage
// Optional macro PIPELINED_RCA_SAT_EN: saturate the sum on signed overflow.
module pipelined_rca #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  // Each stage carries full-width operands and the partial sum; the last stage is the output register.
  logic [STAGES-1:0][WIDTH-1:0] r_a, r_b, r_s;
  logic [STAGES-1:0]            r_c, r_vld;
  logic                         r_ovf;

  logic [STAGES-1:0][WIDTH-1:0] w_a, w_b, w_s;
  logic [STAGES-1:0]            w_ci, w_co, w_vld;
  logic [SEG:0]                 w_seg;
  logic                         w_ovf;
  logic                         w_advance;
  logic                         w_unused;

  assign w_advance = !r_vld[LAST] || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_vld[LAST];
  assign sum       = r_s[LAST];
  assign cout      = r_c[LAST];
  assign overflow  = r_ovf;
  assign w_unused  = ^{r_a[LAST], r_b[LAST]};

  always_comb begin
    w_seg    = '0;
    w_co     = '0;
    w_ovf    = 1'b0;
    w_a[0]   = in1;
    w_b[0]   = sub ? ~in2 : in2;
    w_s[0]   = '0;
    w_ci[0]  = sub ? 1'b1 : cin;
    w_vld[0] = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      w_a[s]   = r_a[s-1];
      w_b[s]   = r_b[s-1];
      w_s[s]   = r_s[s-1];
      w_ci[s]  = r_c[s-1];
      w_vld[s] = r_vld[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      w_seg = {1'b0, w_a[s][s*SEG +: SEG]} + {1'b0, w_b[s][s*SEG +: SEG]}
            + {{SEG{1'b0}}, w_ci[s]};
      w_s[s][s*SEG +: SEG] = w_seg[SEG-1:0];
      w_co[s]              = w_seg[SEG];
    end
    // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ sum.
    w_ovf = w_co[LAST] ^ (w_a[LAST][WIDTH-1] ^ w_b[LAST][WIDTH-1] ^ w_s[LAST][WIDTH-1]);
`ifdef PIPELINED_RCA_SAT_EN
    if (w_ovf) begin
      w_s[LAST] = w_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_s   <= '0;
      r_c   <= '0;
      r_vld <= '0;
      r_ovf <= 1'b0;
    end else if (w_advance) begin
      r_a   <= w_a;
      r_b   <= w_b;
      r_s   <= w_s;
      r_c   <= w_co;
      r_vld <= w_vld;
      r_ovf <= w_ovf;
    end
  end
endmodule
